config_write_scheduler: RTL and testbench
=========================================

// Module: config_write_scheduler
// PURPOSE
//  Shares the fabric configuration write path between two 32-bit word sources: the UART config loader and a self-write port.
//  Arbitrates with a locked round-robin grant and decodes the granted word stream (sync word, row header, frame data).
//  Drives FrameAddressRegister, RowSelect and LongFrameStrobe into the fabric frame/row decoders.
// PARAMETERS
//  NUM_ROWS   16             number of fabric rows; valid row indices 1..NUM_ROWS
//  ROW_SEL_W  5              width of RowSelect; must satisfy 2**ROW_SEL_W > NUM_ROWS
//  SYNC_WORD  32'hFAB0_FAB1  word that moves the decoder from UNSYNCED to SYNCED
// PORTS
//  CLK                  in   1          single clock; all logic on posedge
//  RST                  in   1          asynchronous, active-high reset
//  cfg_enable           in   1          global configuration enable
//  uart_active          in   1          UART source owns a transfer (ComActive)
//  uart_data            in   32         UART word (WriteData)
//  uart_strobe          in   1          UART word valid, 1-cycle pulse
//  self_active          in   1          self-write source owns a transfer
//  self_data            in   32         self-write word
//  self_strobe          in   1          self-write word valid, 1-cycle pulse
//  grant                out  2          one-hot grant: [0] UART, [1] self-write
//  busy                 out  1          high when grant != 0
//  FrameAddressRegister out  32         last frame data word
//  RowSelect            out  ROW_SEL_W  row of the last frame
//  LongFrameStrobe      out  1          1-cycle frame write pulse
//  sync_err             out  1          sticky bad-header flag
// BEHAVIOUR
//  Reset: all outputs 0. Arbiter in ARB_IDLE, decoder in UNSYNCED, round-robin pointer favours UART.
//  Arbiter states: ARB_IDLE, ARB_UART, ARB_SELF, ARB_RELEASE.
//   ARB_IDLE: if cfg_enable and exactly one source is active, grant it next cycle.
//    If both are active, grant the source opposite the last grant, then update the pointer.
//   Granted state: hold grant while that source's active=1. On active=0 go to ARB_RELEASE.
//   ARB_RELEASE: grant=0 for exactly 1 cycle; decoder forced to UNSYNCED; then ARB_IDLE.
//   cfg_enable=0 in any state: next cycle grant=0, ARB_IDLE, decoder UNSYNCED, no strobe.
//    FrameAddressRegister and RowSelect hold their values.
//  Mux: strobe/data of the non-granted source are ignored.
//   Granted strobe at cycle t is registered as word_v/word_d at t+1. Strobes are accepted on every cycle.
//   A strobe in the same cycle the grant is first asserted is ignored; the grant is registered.
//  Decoder states: UNSYNCED, HEADER, DATA; it consumes word_v.
//   UNSYNCED: word==SYNC_WORD -> HEADER and clear sync_err. Other words are dropped.
//   HEADER: word[31]=1 is a desync -> UNSYNCED.
//    Else row=word[ROW_SEL_W-1:0]. If row is 1..NUM_ROWS, latch row and go to DATA.
//    If row is 0 or >NUM_ROWS: set sync_err, stay in HEADER.
//   DATA: FrameAddressRegister<=word and RowSelect<=row at t+2, LongFrameStrobe=1 during t+3 only; -> HEADER.
//    A word equal to SYNC_WORD in DATA is treated as frame data.
//  Latency: data-word strobe at t -> outputs valid at t+2 -> LongFrameStrobe at t+3.
//   Strobes one cycle apart never overlap because a header separates frames.
//  Source drops active mid-frame (in DATA): no strobe for that frame, decoder to UNSYNCED.
//  RST mid-operation: immediate return to reset values; an in-flight strobe is discarded.
// STRUCTURE
//  Package config_sched_pkg holds arbiter and decoder state enums, the default SYNC_WORD, and DESYNC_BIT=31.
//  Sub-module config_rr_arbiter: 2-way locked round-robin (req[1:0], hold[1:0] -> grant[1:0]).
//   Mux and decoder FSM stay in the top module.
// TESTING
//  1. UART active, words FAB0_FAB1, 0x00000003, 0xDEADBEEF -> RowSelect=3, FAR=DEADBEEF at t+2, one strobe at t+3.
//  2. Both sources active in the same cycle after reset -> grant=01.
//     UART drops active -> 1 cycle grant=00 -> grant=10.
//  3. Self-write strobes while UART is granted -> no FAR change, no strobe.
//  4. Header 0x00000000, then 0x00000011 (row 17) -> sync_err=1, no strobe; next SYNC_WORD clears sync_err.
//  5. Header 0x80000000 -> UNSYNCED; following data word 0x12345678 is ignored.
//  6. cfg_enable dropped, or RST asserted, between header and data word -> no strobe.
//     grant=00 next cycle (RST: immediately); decoder re-requires SYNC_WORD.

Source files
------------

// File: rtl/config_sched_pkg.sv
// Shared types and constants for the configuration write scheduler.
//  arbState_t : arbiter FSM states (idle, UART owns path, self-write owns path, release gap)
//  decState_t : word-stream decoder states (waiting for sync, expecting header, expecting data)
//  DEFAULT_SYNC_WORD : word that brings the decoder into sync
//  DESYNC_BIT        : header bit that, when set, drops the decoder back out of sync
package config_sched_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_UART,
    ARB_SELF,
    ARB_RELEASE
  } arbState_t;

  typedef enum logic [1:0] {
    UNSYNCED,
    HEADER,
    DATA
  } decState_t;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;
  localparam int unsigned DESYNC_BIT        = 31;

endpackage

// File: rtl/config_rr_arbiter.sv
// Two-way locked round-robin arbiter for the configuration write path.
// Ports:
//  CLK, RST    clock, asynchronous active-high reset
//  enable      global enable; when low the arbiter returns to idle with no grant
//  req[1:0]    sources asking for a new transfer ([0] UART, [1] self-write)
//  hold[1:0]   sources keeping an existing transfer open
//  grant[1:0]  registered one-hot grant
//  grantFirst  high during the first cycle of a fresh grant
//  releasing   high during the one-cycle release gap after a grant ends
module config_rr_arbiter
  import config_sched_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [1:0] req,
  input  logic [1:0] hold,
  output logic [1:0] grant,
  output logic       grantFirst,
  output logic       releasing
);

  arbState_t  state;
  logic       lastSelf;  // last grant went to self-write
  logic [1:0] pick;

  // With both requesting, the source opposite the previous grant wins.
  always_comb begin
    pick = 2'b00;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = lastSelf ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  assign releasing = (state == ARB_RELEASE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ARB_IDLE;
      grant      <= 2'b00;
      grantFirst <= 1'b0;
      lastSelf   <= 1'b1;  // so the first contended grant goes to UART
    end else if (!enable) begin
      state      <= ARB_IDLE;
      grant      <= 2'b00;
      grantFirst <= 1'b0;
    end else begin
      grantFirst <= 1'b0;
      case (state)
        // The release gap also arbitrates, so a waiting source sees one zero-grant cycle.
        ARB_IDLE, ARB_RELEASE: begin
          if (pick[0]) begin
            state      <= ARB_UART;
            grant      <= 2'b01;
            grantFirst <= 1'b1;
            lastSelf   <= 1'b0;
          end else if (pick[1]) begin
            state      <= ARB_SELF;
            grant      <= 2'b10;
            grantFirst <= 1'b1;
            lastSelf   <= 1'b1;
          end else begin
            state <= ARB_IDLE;
            grant <= 2'b00;
          end
        end
        ARB_UART: begin
          if (!hold[0]) begin
            state <= ARB_RELEASE;
            grant <= 2'b00;
          end
        end
        ARB_SELF: begin
          if (!hold[1]) begin
            state <= ARB_RELEASE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: rtl/config_write_scheduler.sv
// Shares the fabric configuration write path between the UART config loader and a
// self-write port, then decodes the granted word stream (sync, row header, frame data).
// Ports:
//  CLK, RST                      clock, asynchronous active-high reset
//  cfg_enable                    global configuration enable
//  uart_active/data/strobe       UART source: owns transfer, word, 1-cycle word valid
//  self_active/data/strobe       self-write source: same handshake
//  grant[1:0]                    one-hot grant ([0] UART, [1] self-write)
//  busy                          grant is non-zero
//  FrameAddressRegister          last frame data word
//  RowSelect                     row of the last frame
//  LongFrameStrobe               1-cycle frame write pulse
//  sync_err                      sticky bad-header flag, cleared by a sync word
module config_write_scheduler
  import config_sched_pkg::*;
#(
  parameter int unsigned NUM_ROWS  = 16,
  parameter int unsigned ROW_SEL_W = 5,
  parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cfg_enable,
  input  logic                 uart_active,
  input  logic [31:0]          uart_data,
  input  logic                 uart_strobe,
  input  logic                 self_active,
  input  logic [31:0]          self_data,
  input  logic                 self_strobe,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [31:0]          FrameAddressRegister,
  output logic [ROW_SEL_W-1:0] RowSelect,
  output logic                 LongFrameStrobe,
  output logic                 sync_err
);

  logic grantFirst;
  logic releasing;

  config_rr_arbiter uArbiter (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (cfg_enable),
    .req        ({self_active, uart_active}),
    .hold       ({self_active, uart_active}),
    .grant      (grant),
    .grantFirst (grantFirst),
    .releasing  (releasing)
  );

  assign busy = |grant;

  // Word mux: only the granted source is seen, and not on the grant's first cycle.
  logic        accept;
  logic [31:0] acceptData;

  always_comb begin
    accept     = 1'b0;
    acceptData = 32'h0;
    if (!grantFirst) begin
      if (grant[0] && uart_strobe) begin
        accept     = 1'b1;
        acceptData = uart_data;
      end else if (grant[1] && self_strobe) begin
        accept     = 1'b1;
        acceptData = self_data;
      end
    end
  end

  decState_t            decState;
  logic                 wordV;
  logic [31:0]          wordD;
  logic [ROW_SEL_W-1:0] rowLatch;
  logic                 pulsePend;
  logic [ROW_SEL_W-1:0] row;
  logic                 rowValid;

  assign row      = wordD[ROW_SEL_W-1:0];
  assign rowValid = (row != '0) && (row <= ROW_SEL_W'(NUM_ROWS));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wordV                <= 1'b0;
      wordD                <= 32'h0;
      decState             <= UNSYNCED;
      rowLatch             <= '0;
      pulsePend            <= 1'b0;
      FrameAddressRegister <= 32'h0;
      RowSelect            <= '0;
      LongFrameStrobe      <= 1'b0;
      sync_err             <= 1'b0;
    end else begin
      wordV           <= cfg_enable && accept;
      wordD           <= acceptData;
      pulsePend       <= 1'b0;
      // Frame data lands one cycle before the pulse so the decoders see stable inputs.
      LongFrameStrobe <= pulsePend && cfg_enable;
      if (!cfg_enable || releasing) begin
        decState <= UNSYNCED;
      end else if (wordV) begin
        case (decState)
          UNSYNCED: begin
            if (wordD == SYNC_WORD) begin
              decState <= HEADER;
              sync_err <= 1'b0;
            end
          end
          HEADER: begin
            if (wordD[DESYNC_BIT]) begin
              decState <= UNSYNCED;
            end else if (rowValid) begin
              rowLatch <= row;
              decState <= DATA;
            end else begin
              sync_err <= 1'b1;
            end
          end
          DATA: begin
            // Any word here is frame data, including one equal to the sync word.
            FrameAddressRegister <= wordD;
            RowSelect            <= rowLatch;
            pulsePend            <= 1'b1;
            decState             <= HEADER;
          end
          default: decState <= UNSYNCED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_write_scheduler.sv
// Directed bench for config_write_scheduler.
module tb_config_write_scheduler;

  localparam int unsigned ROW_SEL_W = 5;
  localparam logic [31:0] SYNC      = 32'hFAB0_FAB1;

  logic                 CLK;
  logic                 RST;
  logic                 cfg_enable;
  logic                 uart_active;
  logic [31:0]          uart_data;
  logic                 uart_strobe;
  logic                 self_active;
  logic [31:0]          self_data;
  logic                 self_strobe;
  logic [1:0]           grant;
  logic                 busy;
  logic [31:0]          FrameAddressRegister;
  logic [ROW_SEL_W-1:0] RowSelect;
  logic                 LongFrameStrobe;
  logic                 sync_err;

  int checkCount;
  int errCount;
  int strobeCount;
  int s0;

  config_write_scheduler #(
    .NUM_ROWS  (16),
    .ROW_SEL_W (ROW_SEL_W),
    .SYNC_WORD (SYNC)
  ) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .cfg_enable           (cfg_enable),
    .uart_active          (uart_active),
    .uart_data            (uart_data),
    .uart_strobe          (uart_strobe),
    .self_active          (self_active),
    .self_data            (self_data),
    .self_strobe          (self_strobe),
    .grant                (grant),
    .busy                 (busy),
    .FrameAddressRegister (FrameAddressRegister),
    .RowSelect            (RowSelect),
    .LongFrameStrobe      (LongFrameStrobe),
    .sync_err             (sync_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (LongFrameStrobe) strobeCount++;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic sendUart(input logic [31:0] w);
    uart_data   = w;
    uart_strobe = 1'b1;
    step();
    uart_strobe = 1'b0;
  endtask

  task automatic sendSelf(input logic [31:0] w);
    self_data   = w;
    self_strobe = 1'b1;
    step();
    self_strobe = 1'b0;
  endtask

  initial begin
    checkCount  = 0;
    errCount    = 0;
    strobeCount = 0;
    RST         = 1'b1;
    cfg_enable  = 1'b0;
    uart_active = 1'b0;
    uart_data   = 32'h0;
    uart_strobe = 1'b0;
    self_active = 1'b0;
    self_data   = 32'h0;
    self_strobe = 1'b0;
    step();
    step();
    checkVal("rst_grant", 32'(grant), 32'h0);
    checkVal("rst_busy", 32'(busy), 32'h0);
    checkVal("rst_far", FrameAddressRegister, 32'h0);
    checkVal("rst_row", 32'(RowSelect), 32'h0);
    checkVal("rst_strobe", 32'(LongFrameStrobe), 32'h0);
    checkVal("rst_syncerr", 32'(sync_err), 32'h0);

    // Both sources request together: UART wins first.
    RST         = 1'b0;
    cfg_enable  = 1'b1;
    uart_active = 1'b1;
    self_active = 1'b1;
    step();
    checkVal("both_grant", 32'(grant), 32'h1);
    checkVal("both_busy", 32'(busy), 32'h1);

    // Strobe on the grant's first cycle is ignored, so the stream stays unsynced.
    s0 = strobeCount;
    sendUart(SYNC);
    sendUart(32'h0000_0003);
    sendUart(32'hAAAA_AAAA);
    settle();
    checkVal("first_cycle_far", FrameAddressRegister, 32'h0);
    checkVal("first_cycle_cnt", 32'(strobeCount - s0), 32'h0);

    // Basic frame with exact latency.
    s0 = strobeCount;
    sendUart(SYNC);
    sendUart(32'h0000_0003);
    sendUart(32'hDEAD_BEEF);
    checkVal("t1_far", FrameAddressRegister, 32'h0);
    step();
    checkVal("t2_far", FrameAddressRegister, 32'hDEAD_BEEF);
    checkVal("t2_row", 32'(RowSelect), 32'h3);
    checkVal("t2_strobe", 32'(LongFrameStrobe), 32'h0);
    step();
    checkVal("t3_strobe", 32'(LongFrameStrobe), 32'h1);
    step();
    checkVal("t4_strobe", 32'(LongFrameStrobe), 32'h0);
    checkVal("frame1_cnt", 32'(strobeCount - s0), 32'h1);

    // Non-granted source is ignored.
    s0 = strobeCount;
    sendSelf(32'h0000_0005);
    sendSelf(32'h1111_1111);
    settle();
    checkVal("self_ign_far", FrameAddressRegister, 32'hDEAD_BEEF);
    checkVal("self_ign_row", 32'(RowSelect), 32'h3);
    checkVal("self_ign_cnt", 32'(strobeCount - s0), 32'h0);

    // Bad rows set sync_err and keep the decoder in HEADER; row 16 is still valid.
    s0 = strobeCount;
    sendUart(32'h0000_0000);
    step();
    checkVal("row0_err", 32'(sync_err), 32'h1);
    sendUart(32'h0000_0011);
    step();
    checkVal("row17_err", 32'(sync_err), 32'h1);
    checkVal("badrow_cnt", 32'(strobeCount - s0), 32'h0);
    sendUart(32'h0000_0010);
    sendUart(32'h0000_0016);
    settle();
    checkVal("row16_far", FrameAddressRegister, 32'h0000_0016);
    checkVal("row16_row", 32'(RowSelect), 32'h10);
    checkVal("row16_cnt", 32'(strobeCount - s0), 32'h1);

    // Desync header: following data is dropped; sync word then clears sync_err.
    s0 = strobeCount;
    sendUart(32'h8000_0000);
    sendUart(32'h1234_5678);
    settle();
    checkVal("desync_far", FrameAddressRegister, 32'h0000_0016);
    checkVal("desync_cnt", 32'(strobeCount - s0), 32'h0);
    sendUart(SYNC);
    step();
    checkVal("sync_clears_err", 32'(sync_err), 32'h0);

    // UART releases: one zero-grant cycle, then self-write.
    uart_active = 1'b0;
    step();
    checkVal("release_grant", 32'(grant), 32'h0);
    checkVal("release_busy", 32'(busy), 32'h0);
    step();
    checkVal("self_grant", 32'(grant), 32'h2);
    step();

    // cfg_enable dropped between header and data.
    s0 = strobeCount;
    sendSelf(SYNC);
    sendSelf(32'h0000_0009);
    cfg_enable = 1'b0;
    sendSelf(32'h9999_9999);
    checkVal("cfgoff_grant", 32'(grant), 32'h0);
    checkVal("cfgoff_busy", 32'(busy), 32'h0);
    cfg_enable = 1'b1;
    step();
    checkVal("cfgon_grant", 32'(grant), 32'h2);
    step();
    sendSelf(32'h0000_0009);
    sendSelf(32'h9999_9999);
    settle();
    checkVal("cfgoff_far", FrameAddressRegister, 32'h0000_0016);
    checkVal("cfgoff_cnt", 32'(strobeCount - s0), 32'h0);
    s0 = strobeCount;
    sendSelf(SYNC);
    sendSelf(32'h0000_0009);
    sendSelf(32'h55AA_55AA);
    settle();
    checkVal("resync_far", FrameAddressRegister, 32'h55AA_55AA);
    checkVal("resync_row", 32'(RowSelect), 32'h9);
    checkVal("resync_cnt", 32'(strobeCount - s0), 32'h1);

    // Reset mid-frame with a data strobe in flight.
    s0 = strobeCount;
    sendSelf(SYNC);
    sendSelf(32'h0000_0004);
    self_data   = 32'h4444_4444;
    self_strobe = 1'b1;
    RST         = 1'b1;
    #1;
    checkVal("midrst_grant", 32'(grant), 32'h0);
    checkVal("midrst_far", FrameAddressRegister, 32'h0);
    checkVal("midrst_row", 32'(RowSelect), 32'h0);
    step();
    self_strobe = 1'b0;
    step();
    RST = 1'b0;
    step();
    checkVal("postrst_grant", 32'(grant), 32'h2);
    step();
    sendSelf(32'h0000_0004);
    sendSelf(32'h4444_4444);
    settle();
    checkVal("postrst_far", FrameAddressRegister, 32'h0);
    checkVal("postrst_cnt", 32'(strobeCount - s0), 32'h0);

    // Row 1 boundary after resync.
    s0 = strobeCount;
    sendSelf(SYNC);
    sendSelf(32'h0000_0001);
    sendSelf(32'h0101_0101);
    settle();
    checkVal("row1_far", FrameAddressRegister, 32'h0101_0101);
    checkVal("row1_row", 32'(RowSelect), 32'h1);
    checkVal("row1_cnt", 32'(strobeCount - s0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
